instruction_fetch: RTL and testbench

Fetch stage sitting between the PC and the 8-entry, 16-bit program ROM (upstream) and the decode stage (downstream).
- Holds the program counter and drives the ROM address; the ROM read is combinational.
- Registers the returned instruction plus its PC into a single output slot.
- Presents the slot to decode with a valid/ready handshake.
- Supports stall (backpressure), halt, and redirect (branch/jump flush) from later stages.

---
 rtl/instruction_fetch.sv | 57 +++++
 tb/tb_instruction_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, addresses the program
// ROM combinationally and holds one fetched instruction (with its PC) in an
// output slot handed to decode over a valid/ready handshake. Later stages
// can stall it through backpressure, freeze it with halt, or flush it with a
// redirect to a new PC.
module instruction_fetch #(
   parameter int ADDR_W = 3,
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              halt,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [INST_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] pc;
   logic              fire;
   logic              load;

   assign rom_addr = pc;

   // Slot moves to decode when both sides agree.
   assign fire = if_valid & if_ready;

   // A new fetch may land in the slot when it is empty or draining, unless halted.
   assign load = ~halt & (~if_valid | if_ready);

   // PC and output slot update: redirect flushes first, then fetch, then drain, else stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= '0;
         if_valid <= 1'b0;
         if_inst  <= '0;
         if_pc    <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_addr;
         if_valid <= 1'b0;
      end else if (load) begin
         if_inst  <= rom_data;
         if_pc    <= pc;
         if_valid <= 1'b1;
         pc       <= pc + PC_ONE;
      end else if (fire) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for the instruction fetch stage, driving it
// from a small ROM image through streaming, stall, redirect, halt and
// reset-during-stall scenarios.
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic [2:0]  rom_addr;
   logic [15:0] rom_data;
   logic        redirect_valid;
   logic [2:0]  redirect_addr;
   logic        halt;
   logic        if_valid;
   logic        if_ready;
   logic [15:0] if_inst;
   logic [2:0]  if_pc;

   logic [15:0] rom [0:7];

   int checks;
   int failures;

   instruction_fetch #(
      .ADDR_W(3),
      .INST_W(16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_inst        (if_inst),
      .if_pc          (if_pc)
   );

   // Combinational program ROM in front of the fetch stage.
   assign rom_data = rom[rom_addr];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdy, input logic h,
                                input logic rv, input logic [2:0] ra);
      rst_n          = r;
      if_ready       = rdy;
      halt           = h;
      redirect_valid = rv;
      redirect_addr  = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic v, input logic [2:0] pc,
                              input logic [15:0] inst, input logic [2:0] addr);
      chk({tag, ".valid"}, {15'd0, if_valid}, {15'd0, v});
      if (v) begin
         chk({tag, ".pc"},   {13'd0, if_pc}, {13'd0, pc});
         chk({tag, ".inst"}, if_inst, inst);
      end
      chk({tag, ".rom_addr"}, {13'd0, rom_addr}, {13'd0, addr});
   endtask

   initial begin
      logic [15:0] exp_inst [0:7];

      checks   = 0;
      failures = 0;

      rom[0] = 16'h1205; rom[1] = 16'h140A; rom[2] = 16'h0000; rom[3] = 16'h0000;
      rom[4] = 16'hF200; rom[5] = 16'hF400; rom[6] = 16'hF200; rom[7] = 16'hF400;

      exp_inst[0] = 16'h1205; exp_inst[1] = 16'h140A; exp_inst[2] = 16'h0000; exp_inst[3] = 16'h0000;
      exp_inst[4] = 16'hF200; exp_inst[5] = 16'hF400; exp_inst[6] = 16'hF200; exp_inst[7] = 16'hF400;

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      checkOutput("reset", 1'b0, 3'd0, 16'h0, 3'd0);
      chk("reset.pc_reg",   {13'd0, if_pc}, 16'h0);
      chk("reset.inst_reg", if_inst, 16'h0);

      $display("[TB] streaming with wrap");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
         checkOutput($sformatf("stream%0d", i), 1'b1, 3'(i % 8), exp_inst[i % 8], 3'((i + 1) % 8));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("stream_p2", 1'b1, 3'd2, 16'h0000, 3'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("stream_p3", 1'b1, 3'd3, 16'h0000, 3'd4);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("stream_p4", 1'b1, 3'd4, 16'hF200, 3'd5);

      $display("[TB] stall");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
         checkOutput($sformatf("stall%0d", i), 1'b1, 3'd4, 16'hF200, 3'd5);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("stall_release", 1'b1, 3'd5, 16'hF400, 3'd6);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("post_stall_p6", 1'b1, 3'd6, 16'hF200, 3'd7);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("post_stall_p7", 1'b1, 3'd7, 16'hF400, 3'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("post_stall_p0", 1'b1, 3'd0, 16'h1205, 3'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("post_stall_p1", 1'b1, 3'd1, 16'h140A, 3'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("post_stall_p2", 1'b1, 3'd2, 16'h0000, 3'd3);

      $display("[TB] redirect");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
      checkOutput("redir_bubble", 1'b0, 3'd0, 16'h0, 3'd6);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_p6", 1'b1, 3'd6, 16'hF200, 3'd7);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_p7", 1'b1, 3'd7, 16'hF400, 3'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_p0", 1'b1, 3'd0, 16'h1205, 3'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_p1", 1'b1, 3'd1, 16'h140A, 3'd2);

      $display("[TB] halt");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
         checkOutput($sformatf("halt%0d", i), 1'b0, 3'd0, 16'h0, 3'd2);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("halt_resume", 1'b1, 3'd2, 16'h0000, 3'd3);

      $display("[TB] redirect with halt");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
      checkOutput("redir_halt", 1'b0, 3'd0, 16'h0, 3'd5);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      checkOutput("redir_halt_hold", 1'b0, 3'd0, 16'h0, 3'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_halt_p5", 1'b1, 3'd5, 16'hF400, 3'd6);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("redir_halt_p6", 1'b1, 3'd6, 16'hF200, 3'd7);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("walk_p7", 1'b1, 3'd7, 16'hF400, 3'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("walk_p0", 1'b1, 3'd0, 16'h1205, 3'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("walk_p1", 1'b1, 3'd1, 16'h140A, 3'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("walk_p2", 1'b1, 3'd2, 16'h0000, 3'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("walk_p3", 1'b1, 3'd3, 16'h0000, 3'd4);

      $display("[TB] reset during stall");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      checkOutput("stall_p3", 1'b1, 3'd3, 16'h0000, 3'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      checkOutput("mid_reset", 1'b0, 3'd0, 16'h0, 3'd0);
      chk("mid_reset.pc_reg",   {13'd0, if_pc}, 16'h0);
      chk("mid_reset.inst_reg", if_inst, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      checkOutput("restart_p0", 1'b1, 3'd0, 16'h1205, 3'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
